// File: rtl/peak_pkg.sv
// peak_pkg: shared types and helpers for the peak_sched frame scheduler.
//   sched_state_t : scheduler FSM states
//   beat_t        : one stream beat {sop, eop, mag, phase}
//   SRC_A / SRC_B : source ids used for grant encoding
//   sat_add16     : saturating 16-bit accumulate used by the drop counters
package peak_pkg;

  // Magnitude width carried in beat_t. It must match the detector width.
  localparam int MAG_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2,
    FLUSH    = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [MAG_W-1:0] mag;
    logic [15:0]      phase;
  } beat_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/peak_sched_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req       in  2  request per source (bit 0 = A, bit 1 = B)
//   last      in  1  source granted most recently
//   gnt_valid out 1  at least one request present
//   gnt       out 1  winning source; on a tie the source that did not win last
module rr_arb2
  import peak_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt
);

  always_comb begin
    gnt_valid = |req;
    case (req)
      2'b01:   gnt = SRC_A;
      2'b10:   gnt = SRC_B;
      2'b11:   gnt = ~last;
      default: gnt = last;
    endcase
  end

endmodule

// File: rtl/peak_sched.sv
// peak_sched: shares one peak_detect instance between FFT channels A and B.
// Whole frames (sop..eop) are granted round-robin, the frame length is
// checked against NBINS, the next frame is held off until the detector has
// reported (or TIMEOUT expired), and the detector is reset after every frame.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   a_* / b_*                  input streams (valid/sop/eop/mag/phase) and ready
//   det_valid/sop/eop/mag/phase registered stream to the detector
//   det_reset                  one-cycle detector reset (also held in reset)
//   det_done                   detector result present
//   grant                      source of current/last frame (0 = A, 1 = B)
//   busy                       FSM not in IDLE
//   err                        one-cycle pulse on length error or timeout
//   dbg_state                  current FSM state
//   drops_a, drops_b           saturating drop counters (PEAK_SCHED_STATS_EN only)
//
// Handshake: a beat transfers on a cycle where valid && ready are both high.
// Ready has zero latency and, in IDLE, depends combinationally on the sop
// requests of both channels (the tie loser sees ready = 0).
//
// Build option: define PEAK_SCHED_STATS_EN to add the drop counters.
module peak_sched
  import peak_pkg::*;
#(
  parameter int WIDTH   = MAG_W,
  parameter int NBINS   = 1024,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic             a_sop,
  input  logic             a_eop,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [15:0]      a_phase,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic             b_sop,
  input  logic             b_eop,
  input  logic [WIDTH-1:0] b_mag,
  input  logic [15:0]      b_phase,
  output logic             b_ready,
  output logic             det_valid,
  output logic             det_sop,
  output logic             det_eop,
  output logic [WIDTH-1:0] det_mag,
  output logic [15:0]      det_phase,
  output logic             det_reset,
  input  logic             det_done,
  output logic             grant,
  output logic             busy,
  output logic             err,
  output sched_state_t     dbg_state
`ifdef PEAK_SCHED_STATS_EN
  ,
  output logic [15:0]      drops_a,
  output logic [15:0]      drops_b
`endif
);

  localparam int CW = $clog2(NBINS) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_BIN = CW'(NBINS - 1);
  localparam logic [CW-1:0] FULL_BIN = CW'(NBINS);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  sched_state_t  state, state_nx;
  logic [CW-1:0] bin_cnt;
  logic [TW-1:0] t_cnt;
  logic          grant_q;

  logic  a_sop_req, b_sop_req;
  logic  arb_valid, arb_gnt;
  logic  src;
  beat_t a_beat, b_beat, sel;
  logic  sel_valid, sel_ready;
  logic  fwd;
  logic  len_err, tmo, err_cond;

  assign a_sop_req = a_valid & a_sop;
  assign b_sop_req = b_valid & b_sop;

  rr_arb2 u_arb (
    .req       ({b_sop_req, a_sop_req}),
    .last      (grant_q),
    .gnt_valid (arb_valid),
    .gnt       (arb_gnt)
  );

  // In IDLE the arbiter decides the source; afterwards the frame owner does.
  assign src    = (state == IDLE) ? arb_gnt : grant_q;
  assign a_beat = '{sop: a_sop, eop: a_eop, mag: a_mag, phase: a_phase};
  assign b_beat = '{sop: b_sop, eop: b_eop, mag: b_mag, phase: b_phase};
  assign sel       = (src == SRC_B) ? b_beat  : a_beat;
  assign sel_valid = (src == SRC_B) ? b_valid : a_valid;
  assign sel_ready = (src == SRC_B) ? b_ready : a_ready;

  // IDLE accepts everything but only forwards the winning sop beat.
  assign fwd = sel_valid & sel_ready & ((state != IDLE) | sel.sop);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    len_err  = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: begin
        if (fwd) begin
          // A one-beat frame is always short because NBINS > 1.
          if (sel.eop) len_err = 1'b1;
          else         state_nx = STREAM;
        end
      end
      STREAM: begin
        if (fwd) begin
          if (sel.sop)                len_err  = 1'b1;
          else if (sel.eop)
            if (bin_cnt == LAST_BIN)  state_nx = WAIT_RES;
            else                      len_err  = 1'b1;
          // Last legal beat without eop: the count would hit NBINS.
          else if (bin_cnt == LAST_BIN) len_err = 1'b1;
        end
      end
      WAIT_RES: begin
        if (det_done)             state_nx = FLUSH;
        else if (t_cnt == T_LAST) tmo      = 1'b1;
      end
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (len_err | tmo) state_nx = FLUSH;
  end

  assign err_cond = len_err | tmo;

  // Output logic
  always_comb begin
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    busy      = (state != IDLE);
    dbg_state = state;
    if (!reset) begin
      case (state)
        IDLE: begin
          a_ready = ~(a_sop_req & b_sop_req & (arb_gnt == SRC_B));
          b_ready = ~(a_sop_req & b_sop_req & (arb_gnt == SRC_A));
        end
        STREAM: begin
          a_ready = (grant_q == SRC_A);
          b_ready = (grant_q == SRC_B);
        end
        default: ;
      endcase
    end
  end

  // Datapath and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_cnt   <= '0;
      t_cnt     <= '0;
      grant_q   <= SRC_B;
      det_valid <= 1'b0;
      det_sop   <= 1'b0;
      det_eop   <= 1'b0;
      det_mag   <= '0;
      det_phase <= '0;
      det_reset <= 1'b1;
      err       <= 1'b0;
    end else begin
      det_valid <= fwd;
      det_sop   <= fwd & sel.sop;
      det_eop   <= fwd & sel.eop;
      if (fwd) begin
        det_mag   <= sel.mag;
        det_phase <= sel.phase;
      end
      det_reset <= (state_nx == FLUSH);
      err       <= err_cond;
      if (state == IDLE && fwd) begin
        grant_q <= arb_gnt;
        bin_cnt <= CW'(1);
      end else if (state == STREAM && fwd && bin_cnt != FULL_BIN) begin
        bin_cnt <= bin_cnt + CW'(1);
      end
      // Held at zero outside WAIT_RES, so it is clear on entry.
      if (state != WAIT_RES) t_cnt <= '0;
      else                   t_cnt <= t_cnt + TW'(1);
    end
  end

  assign grant = grant_q;

`ifdef PEAK_SCHED_STATS_EN
  // A refused sop is counted once while it stays presented; an aborted
  // frame counts against its owner.
  logic       a_refused, b_refused, a_hold, b_hold;
  logic [1:0] a_inc, b_inc;

  assign a_refused = a_sop_req & ~a_ready;
  assign b_refused = b_sop_req & ~b_ready;

  always_comb begin
    a_inc = {1'b0, a_refused & ~a_hold} + {1'b0, err_cond & (src == SRC_A)};
    b_inc = {1'b0, b_refused & ~b_hold} + {1'b0, err_cond & (src == SRC_B)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_hold  <= 1'b0;
      b_hold  <= 1'b0;
      drops_a <= '0;
      drops_b <= '0;
    end else begin
      a_hold  <= a_refused;
      b_hold  <= b_refused;
      drops_a <= sat_add16(drops_a, a_inc);
      drops_b <= sat_add16(drops_b, b_inc);
    end
  end
`endif

endmodule

// File: tb/tb_peak_sched.sv
// tb_peak_sched: directed bench for peak_sched. A negedge monitor checks every
// detector beat against an expected queue filled by the frame driver.
module tb_peak_sched;
  import peak_pkg::*;

  logic        clk, reset;
  logic        a_valid, a_sop, a_eop, a_ready;
  logic [15:0] a_mag, a_phase;
  logic        b_valid, b_sop, b_eop, b_ready;
  logic [15:0] b_mag, b_phase;
  logic        det_valid, det_sop, det_eop, det_reset, det_done;
  logic [15:0] det_mag, det_phase;
  logic        grant, busy, err;
  sched_state_t dbg_state;
`ifdef PEAK_SCHED_STATS_EN
  logic [15:0] drops_a, drops_b;
`endif

  peak_sched dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_sop(a_sop), .a_eop(a_eop), .a_mag(a_mag), .a_phase(a_phase), .a_ready(a_ready),
    .b_valid(b_valid), .b_sop(b_sop), .b_eop(b_eop), .b_mag(b_mag), .b_phase(b_phase), .b_ready(b_ready),
    .det_valid(det_valid), .det_sop(det_sop), .det_eop(det_eop), .det_mag(det_mag),
    .det_phase(det_phase), .det_reset(det_reset), .det_done(det_done),
    .grant(grant), .busy(busy), .err(err), .dbg_state(dbg_state)
`ifdef PEAK_SCHED_STATS_EN
    , .drops_a(drops_a), .drops_b(drops_b)
`endif
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [33:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic src, input int i, input int eop_at, output logic [33:0] beat);
    logic [15:0] mag, ph;
    mag  = 16'(i);
    ph   = 16'(i * 7) ^ (src ? 16'h4000 : 16'h0000);
    beat = {(i == 0), (i == eop_at), ph, mag};
    if (src == SRC_A) begin
      a_valid = 1'b1; a_sop = (i == 0); a_eop = (i == eop_at); a_mag = mag; a_phase = ph;
    end else begin
      b_valid = 1'b1; b_sop = (i == 0); b_eop = (i == eop_at); b_mag = mag; b_phase = ph;
    end
  endtask

  task automatic idle_src(input logic src);
    if (src == SRC_A) begin a_valid = 1'b0; a_sop = 1'b0; a_eop = 1'b0; end
    else              begin b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0; end
  endtask

  // Sends beats 0..n-1; eop_at < 0 means no eop. Returns one cycle after the
  // last beat was accepted, with the source idled.
  task automatic send_frame(input logic src, input int n, input int eop_at, input bit chk_other);
    logic [33:0] beat;
    for (int i = 0; i < n; i++) begin
      drive_beat(src, i, eop_at, beat);
      #1;
      chk("src_ready", (src == SRC_A) ? a_ready : b_ready, 1'b1);
      if (chk_other) chk("other_ready", (src == SRC_A) ? b_ready : a_ready, 1'b0);
      exp_q.push_back(beat);
      @(posedge clk);
      #1;
      if (i == 0) begin
        chk("first_det_valid", det_valid, 1'b1);
        chk("first_det_sop", det_sop, 1'b1);
        chk("first_grant", grant, src);
        chk("first_busy", busy, 1'b1);
      end
      if (i < n - 1) chk("no_early_err", err, 1'b0);
    end
    idle_src(src);
  endtask

  // Scoreboard: every detector beat must match the next expected beat.
  always @(negedge clk) begin
    if (det_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("det_unexpected_beat", det_valid, 1'b0);
      else chk("det_beat", {det_sop, det_eop, det_phase, det_mag}, exp_q.pop_front());
    end
  end

  initial begin
    logic [33:0] dummy;
    reset = 1'b1; det_done = 1'b0;
    a_valid = 0; a_sop = 0; a_eop = 0; a_mag = 0; a_phase = 0;
    b_valid = 0; b_sop = 0; b_eop = 0; b_mag = 0; b_phase = 0;
    repeat (3) tick();

    // Reset values
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_det_valid", det_valid, 1'b0);
    chk("rst_det_mag", det_mag, 16'h0);
    chk("rst_det_phase", det_phase, 16'h0);
    chk("rst_det_reset", det_reset, 1'b1);
    chk("rst_grant", grant, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_rst_det_reset", det_reset, 1'b1);
    chk("post_rst_a_ready", a_ready, 1'b1);
    tick();
    chk("post_rst_det_reset_drop", det_reset, 1'b0);

    // Full A frame, result 5 cycles after eop
    send_frame(SRC_A, 1024, 1023, 1'b0);
    chk("t1_state_wait", dbg_state, WAIT_RES);
    chk("t1_det_eop", det_eop, 1'b1);
    chk("t1_a_ready_wait", a_ready, 1'b0);
    repeat (4) tick();
    chk("t1_still_wait", dbg_state, WAIT_RES);
    det_done = 1'b1;
    tick();
    det_done = 1'b0;
    chk("t1_flush", dbg_state, FLUSH);
    chk("t1_det_reset", det_reset, 1'b1);
    chk("t1_no_err", err, 1'b0);
    tick();
    chk("t1_idle", dbg_state, IDLE);
    chk("t1_det_reset_drop", det_reset, 1'b0);
    chk("t1_busy", busy, 1'b0);

    // A and B sop together after reset: A wins, B waits
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    b_valid = 1'b1; b_sop = 1'b1; b_eop = 1'b0; b_mag = 16'h0; b_phase = 16'h4000;
    send_frame(SRC_A, 1024, 1023, 1'b1);
    chk("t2_b_ready_wait", b_ready, 1'b0);
    det_done = 1'b1;
    tick();
    det_done = 1'b0;
    chk("t2_b_ready_flush", b_ready, 1'b0);
    tick();
    send_frame(SRC_B, 1024, 1023, 1'b0);
    chk("t2_grant_b", grant, 1'b1);
    det_done = 1'b1;
    tick();
    det_done = 1'b0;
    tick();
    chk("t2_idle", busy, 1'b0);

    // A frame with eop at beat 500: short frame error
    send_frame(SRC_A, 501, 500, 1'b0);
    chk("t3_err", err, 1'b1);
    chk("t3_flush", dbg_state, FLUSH);
    chk("t3_det_reset", det_reset, 1'b1);
`ifdef PEAK_SCHED_STATS_EN
    chk("t3_drops_a", drops_a, 16'd1);
`endif
    tick();
    chk("t3_idle", dbg_state, IDLE);
    chk("t3_err_drop", err, 1'b0);

    // A frame without eop: overflow error on beat 1024
    send_frame(SRC_A, 1024, -1, 1'b0);
    chk("t4_err", err, 1'b1);
    chk("t4_flush", dbg_state, FLUSH);
    tick();
    chk("t4_idle", dbg_state, IDLE);

    // det_done outside WAIT_RES is ignored
    det_done = 1'b1;
    tick();
    det_done = 1'b0;
    chk("t5_done_ignored_busy", busy, 1'b0);
    chk("t5_done_ignored_rst", det_reset, 1'b0);

    // Detector never answers: timeout after 4096 cycles in WAIT_RES
    send_frame(SRC_A, 1024, 1023, 1'b0);
    chk("t5_wait", dbg_state, WAIT_RES);
    repeat (4095) tick();
    chk("t5_wait_last", dbg_state, WAIT_RES);
    chk("t5_no_err_yet", err, 1'b0);
    tick();
    chk("t5_err", err, 1'b1);
    chk("t5_flush", dbg_state, FLUSH);
    chk("t5_det_reset", det_reset, 1'b1);
    tick();
    chk("t5_idle", dbg_state, IDLE);

    // Reset in the middle of a B frame, then a clean A frame
    send_frame(SRC_B, 300, -1, 1'b0);
    reset = 1'b1;
    drive_beat(SRC_B, 300, -1, dummy);
    #1;
    chk("t6_b_ready_rst", b_ready, 1'b0);
    tick();
    chk("t6_busy", busy, 1'b0);
    chk("t6_det_valid", det_valid, 1'b0);
    chk("t6_det_reset", det_reset, 1'b1);
    reset = 1'b0;
    idle_src(SRC_B);
    tick();
    send_frame(SRC_A, 1024, 1023, 1'b0);
    chk("t6_wait", dbg_state, WAIT_RES);
    det_done = 1'b1;
    tick();
    det_done = 1'b0;
    chk("t6_det_reset_flush", det_reset, 1'b1);
    tick();
    chk("t6_idle", busy, 1'b0);
    tick();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
